mem_write_buffer: RTL and testbench

- Posted-write buffer placed between the 16-bit CPU memory port and the 8-bit external bus sequencer.
- CPU writes are acknowledged as soon as they are queued in a small FIFO, then drained to the sequencer in order.
- Reads are issued to the sequencer only when no queued write can produce a read-after-write hazard.
- Lets the CPU continue past stores while the multi-cycle byte-serial bus transfers complete.

---
 rtl/mem_write_buffer.sv | 191 +++++++++++++++++++
 tb/tb_mem_write_buffer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the 16-bit CPU port and the 8-bit bus sequencer.
// Define MEM_WB_BYPASS_EN to let non-conflicting reads overtake queued writes.
module mem_write_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] c_raddr,
  input  logic          c_rreq,
  output logic [15:0]   c_rdata,
  output logic          c_rdone,
  input  logic [AW-1:0] c_waddr,
  input  logic [1:0]    c_wmask,
  input  logic [15:0]   c_wdata,
  output logic          c_wdone,
  output logic [AW-1:0] m_raddr,
  output logic          m_rreq,
  input  logic [15:0]   m_rdata,
  input  logic          m_rdone,
  output logic [AW-1:0] m_waddr,
  output logic [1:0]    m_wmask,
  output logic [15:0]   m_wdata,
  input  logic          m_wdone,
  output logic          idle
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-1:0] r_faddr [DEPTH];
  logic [1:0]    r_fmask [DEPTH];
  logic [15:0]   r_fdata [DEPTH];

  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [PW:0]   w_wptr_nxt;
  logic [PW:0]   w_rptr_nxt;
  logic [PW-1:0] w_widx;
  logic [PW-1:0] w_ridx;

  logic          r_wdone;
  logic          r_rdone;
  logic [15:0]   r_rdata;
  logic          r_idle;
  logic [AW-1:0] r_raddr;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_rd_ok;
  logic w_rd_go;
  logic w_rd_fin;

  assign w_widx = r_wptr[PW-1:0];
  assign w_ridx = r_rptr[PW-1:0];

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (w_widx == w_ridx);

  assign w_pop  = (r_state == S_WR) && m_wdone;
  // A full FIFO still accepts a push in the cycle its head pops.
  assign w_push = (c_wmask != 2'b00) && !r_wdone &&
                  (!w_full || w_pop);

  assign w_wptr_nxt = w_push ? r_wptr + (PW+1)'(1) : r_wptr;
  assign w_rptr_nxt = w_pop  ? r_rptr + (PW+1)'(1) : r_rptr;

`ifdef MEM_WB_BYPASS_EN
  logic [DEPTH-1:0] r_vld;
  logic             w_hit;

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_faddr[i] == c_raddr)) begin
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      if (w_pop) begin
        r_vld[w_ridx] <= 1'b0;
      end
      if (w_push) begin
        r_vld[w_widx] <= 1'b1;
      end
    end
  end

  assign w_rd_ok = c_rreq && !r_rdone &&
                   (r_state == S_IDLE) && !w_hit;
`else
  assign w_rd_ok = c_rreq && !r_rdone &&
                   (r_state == S_IDLE) && w_empty;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_faddr[w_widx] <= c_waddr;
      r_fmask[w_widx] <= c_wmask;
      r_fdata[w_widx] <= c_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    m_rreq      = 1'b0;
    m_wmask     = 2'b00;
    w_rd_go     = 1'b0;
    w_rd_fin    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rd_ok) begin
          w_rd_go     = 1'b1;
          w_state_nxt = S_RD;
        end else if (!w_empty) begin
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (m_wdone) begin
          w_state_nxt = S_IDLE;
        end else begin
          m_wmask = r_fmask[w_ridx];
        end
      end
      S_RD: begin
        if (m_rdone) begin
          w_rd_fin    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          m_rreq = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_wdone <= 1'b0;
      r_rdone <= 1'b0;
      r_rdata <= 16'h0000;
      r_idle  <= 1'b1;
      r_raddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_wdone <= w_push;
      r_rdone <= w_rd_fin;
      r_idle  <= (w_wptr_nxt == w_rptr_nxt) &&
                 (w_state_nxt == S_IDLE);
      if (w_rd_go) begin
        r_raddr <= c_raddr;
      end
      if (w_rd_fin) begin
        r_rdata <= m_rdata;
      end
    end
  end

  assign m_waddr = r_faddr[w_ridx];
  assign m_wdata = r_fdata[w_ridx];
  assign m_raddr = r_raddr;
  assign c_wdone = r_wdone;
  assign c_rdone = r_rdone;
  assign c_rdata = r_rdata;
  assign idle    = r_idle;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: vector table plus corner sequences.
// Bypass checks are compiled in when MEM_WB_BYPASS_EN is defined.
module tb_mem_write_buffer;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] c_raddr;
  logic          c_rreq;
  logic [15:0]   c_rdata;
  logic          c_rdone;
  logic [AW-1:0] c_waddr;
  logic [1:0]    c_wmask;
  logic [15:0]   c_wdata;
  logic          c_wdone;
  logic [AW-1:0] m_raddr;
  logic          m_rreq;
  logic [15:0]   m_rdata;
  logic          m_rdone;
  logic [AW-1:0] m_waddr;
  logic [1:0]    m_wmask;
  logic [15:0]   m_wdata;
  logic          m_wdone;
  logic          idle;

  int total = 0;
  int bad   = 0;

  mem_write_buffer #(.DEPTH(2), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .c_raddr (c_raddr),
    .c_rreq  (c_rreq),
    .c_rdata (c_rdata),
    .c_rdone (c_rdone),
    .c_waddr (c_waddr),
    .c_wmask (c_wmask),
    .c_wdata (c_wdata),
    .c_wdone (c_wdone),
    .m_raddr (m_raddr),
    .m_rreq  (m_rreq),
    .m_rdata (m_rdata),
    .m_rdone (m_rdone),
    .m_waddr (m_waddr),
    .m_wmask (m_wmask),
    .m_wdata (m_wdata),
    .m_wdone (m_wdone),
    .idle    (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [14:0] addr;
    logic [1:0]  mask;
    logic [15:0] data;
    int          dly;
    logic [14:0] exp_addr;
    logic [1:0]  exp_mask;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic do_write(input vec_t v);
    c_waddr = v.addr;
    c_wmask = v.mask;
    c_wdata = v.data;
    cyc();
    chk("wr_wdone", 32'(c_wdone), 32'd1);
    c_wmask = 2'b00;
    cyc();
    chk("wr_wdone_off", 32'(c_wdone), 32'd0);
    chk("wr_idle_busy", 32'(idle), 32'd0);
    for (int k = 0; k < v.dly; k++) cyc();
    chk("wr_addr", 32'(m_waddr), 32'(v.exp_addr));
    chk("wr_mask", 32'(m_wmask), 32'(v.exp_mask));
    chk("wr_data", 32'(m_wdata), 32'(v.exp_data));
    m_wdone = 1'b1;
    #1;
    chk("wr_mask_forced", 32'(m_wmask), 32'd0);
    cyc();
    m_wdone = 1'b0;
    chk("wr_idle_back", 32'(idle), 32'd1);
    chk("wr_no_req", 32'(m_wmask), 32'd0);
  endtask

  task automatic do_read(input vec_t v);
    c_raddr = v.addr;
    c_rreq  = 1'b1;
    cyc();
    chk("rd_rreq", 32'(m_rreq), 32'd1);
    chk("rd_raddr", 32'(m_raddr), 32'(v.exp_addr));
    for (int k = 0; k < v.dly; k++) cyc();
    chk("rd_rdone_early", 32'(c_rdone), 32'd0);
    m_rdata = v.data;
    m_rdone = 1'b1;
    #1;
    chk("rd_rreq_forced", 32'(m_rreq), 32'd0);
    cyc();
    m_rdone = 1'b0;
    m_rdata = 16'h0000;
    chk("rd_rdone", 32'(c_rdone), 32'd1);
    chk("rd_rdata", 32'(c_rdata), 32'(v.exp_data));
    c_rreq = 1'b0;
    cyc();
    chk("rd_rdone_once", 32'(c_rdone), 32'd0);
    chk("rd_no_reissue", 32'(m_rreq), 32'd0);
  endtask

  task automatic pulse_wdone();
    m_wdone = 1'b1;
    cyc();
    m_wdone = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 15'h0040, 2'b11, 16'h1234, 5,
                15'h0040, 2'b11, 16'h1234};
    vecs[1] = '{1, 15'h0100, 2'b00, 16'hBEEF, 2,
                15'h0100, 2'b00, 16'hBEEF};
    vecs[2] = '{0, 15'h7FFF, 2'b01, 16'h00FF, 1,
                15'h7FFF, 2'b01, 16'h00FF};
    vecs[3] = '{0, 15'h0000, 2'b10, 16'hAB00, 0,
                15'h0000, 2'b10, 16'hAB00};
    vecs[4] = '{1, 15'h0001, 2'b00, 16'h8001, 0,
                15'h0001, 2'b00, 16'h8001};

    rst_n   = 1'b0;
    c_raddr = '0;
    c_rreq  = 1'b0;
    c_waddr = '0;
    c_wmask = 2'b00;
    c_wdata = 16'h0000;
    m_rdata = 16'h0000;
    m_rdone = 1'b0;
    m_wdone = 1'b0;
    cyc();
    cyc();
    chk("rst_wdone", 32'(c_wdone), 32'd0);
    chk("rst_rdone", 32'(c_rdone), 32'd0);
    chk("rst_rdata", 32'(c_rdata), 32'd0);
    chk("rst_rreq", 32'(m_rreq), 32'd0);
    chk("rst_wmask", 32'(m_wmask), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_rreq", 32'(m_rreq), 32'd0);
    chk("post_rst_wmask", 32'(m_wmask), 32'd0);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].rd) do_read(vecs[i]);
      else            do_write(vecs[i]);
    end

    // burst of three writes into a two-entry FIFO
    c_waddr = 15'd1; c_wdata = 16'hA001; c_wmask = 2'b11;
    cyc();
    chk("b1_wdone", 32'(c_wdone), 32'd1);
    c_waddr = 15'd2; c_wdata = 16'hA002;
    cyc();
    chk("b_gap", 32'(c_wdone), 32'd0);
    cyc();
    chk("b2_wdone", 32'(c_wdone), 32'd1);
    c_waddr = 15'd3; c_wdata = 16'hA003;
    cyc();
    chk("b_gap2", 32'(c_wdone), 32'd0);
    cyc();
    chk("b3_withheld", 32'(c_wdone), 32'd0);
    cyc();
    chk("b3_withheld2", 32'(c_wdone), 32'd0);
    chk("b_head1", 32'(m_waddr), 32'd1);
    chk("b_data1", 32'(m_wdata), 32'hA001);
    pulse_wdone();
    chk("b3_wdone", 32'(c_wdone), 32'd1);
    c_wmask = 2'b00;
    cyc();
    chk("b_head2", 32'(m_waddr), 32'd2);
    chk("b_data2", 32'(m_wdata), 32'hA002);
    pulse_wdone();
    cyc();
    chk("b_head3", 32'(m_waddr), 32'd3);
    chk("b_data3", 32'(m_wdata), 32'hA003);
    chk("b_mask3", 32'(m_wmask), 32'd3);
    pulse_wdone();
    chk("b_idle", 32'(idle), 32'd1);
    cyc();
    chk("b_drained", 32'(m_wmask), 32'd0);

    // read-after-write to the same word waits for the drain
    c_waddr = 15'h0200; c_wdata = 16'h5555; c_wmask = 2'b11;
    cyc();
    chk("raw_wdone", 32'(c_wdone), 32'd1);
    c_wmask = 2'b00;
    c_raddr = 15'h0200;
    c_rreq  = 1'b1;
    cyc();
    chk("raw_wr_first", 32'(m_waddr), 32'h0200);
    chk("raw_hold0", 32'(m_rreq), 32'd0);
    cyc();
    cyc();
    chk("raw_hold1", 32'(m_rreq), 32'd0);
    pulse_wdone();
    chk("raw_hold2", 32'(m_rreq), 32'd0);
    cyc();
    chk("raw_rreq", 32'(m_rreq), 32'd1);
    chk("raw_raddr", 32'(m_raddr), 32'h0200);
    m_rdata = 16'h5555;
    m_rdone = 1'b1;
    cyc();
    m_rdone = 1'b0;
    chk("raw_rdone", 32'(c_rdone), 32'd1);
    chk("raw_rdata", 32'(c_rdata), 32'h5555);
    c_rreq = 1'b0;
    cyc();

`ifdef MEM_WB_BYPASS_EN
    c_waddr = 15'h0010; c_wdata = 16'h1010; c_wmask = 2'b11;
    cyc();
    c_waddr = 15'h0011; c_wdata = 16'h1111;
    cyc();
    cyc();
    chk("bp_q2", 32'(c_wdone), 32'd1);
    c_wmask = 2'b00;
    c_raddr = 15'h0050;
    c_rreq  = 1'b1;
    cyc();
    chk("bp_wr10", 32'(m_waddr), 32'h0010);
    pulse_wdone();
    cyc();
    chk("bp_rreq", 32'(m_rreq), 32'd1);
    chk("bp_raddr", 32'(m_raddr), 32'h0050);
    chk("bp_ahead", 32'(m_wmask), 32'd0);
    m_rdata = 16'h5050;
    m_rdone = 1'b1;
    cyc();
    m_rdone = 1'b0;
    chk("bp_rdata", 32'(c_rdata), 32'h5050);
    c_rreq = 1'b0;
    cyc();
    chk("bp_wr11", 32'(m_waddr), 32'h0011);
    pulse_wdone();
    cyc();
    c_waddr = 15'h0010; c_wdata = 16'h2010; c_wmask = 2'b11;
    cyc();
    c_waddr = 15'h0011; c_wdata = 16'h2011;
    cyc();
    cyc();
    c_wmask = 2'b00;
    c_raddr = 15'h0011;
    c_rreq  = 1'b1;
    cyc();
    chk("bm_wait0", 32'(m_rreq), 32'd0);
    pulse_wdone();
    cyc();
    chk("bm_wait1", 32'(m_rreq), 32'd0);
    chk("bm_wr11", 32'(m_waddr), 32'h0011);
    pulse_wdone();
    cyc();
    chk("bm_rreq", 32'(m_rreq), 32'd1);
    m_rdata = 16'h2011;
    m_rdone = 1'b1;
    cyc();
    m_rdone = 1'b0;
    chk("bm_rdata", 32'(c_rdata), 32'h2011);
    c_rreq = 1'b0;
    cyc();
`endif

    // reset while draining with two entries queued
    c_waddr = 15'h0030; c_wdata = 16'h3030; c_wmask = 2'b11;
    cyc();
    c_waddr = 15'h0031; c_wdata = 16'h3131;
    cyc();
    cyc();
    chk("mr_q2", 32'(c_wdone), 32'd1);
    c_wmask = 2'b00;
    chk("mr_in_wr", 32'(m_wmask), 32'd3);
    rst_n = 1'b0;
    cyc();
    chk("mr_wdone", 32'(c_wdone), 32'd0);
    chk("mr_rdone", 32'(c_rdone), 32'd0);
    chk("mr_rdata", 32'(c_rdata), 32'd0);
    chk("mr_rreq", 32'(m_rreq), 32'd0);
    chk("mr_wmask", 32'(m_wmask), 32'd0);
    chk("mr_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("mr_no_replay", 32'(m_wmask), 32'd0);
      chk("mr_still_idle", 32'(idle), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
